// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU core with req/ack instruction and data memory ports.
// Optional self-loop halt detection is enabled by defining CPU_HALT_DETECT_EN.
module hack_cpu_mc #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [DATA_W-1:0] imem_data_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_data_o,
    input  logic              dmem_ack_i,
    input  logic [DATA_W-1:0] dmem_data_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              retire_o,
    output logic              halt_o
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        READ,
        EXEC,
        WRITE
`ifdef CPU_HALT_DETECT_EN
        , HALT
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, d_q, d_d, ir_q, ir_d, mdr_q, mdr_d, wdata_q, wdata_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              retire_q, retire_d;
    logic              imem_req_q, dmem_req_q, dmem_we_q;
    logic              halt_q, halt_d;

    logic [DATA_W-1:0] alu_x_c, alu_y_c, alu_r_c;
    logic              is_c_c, zr_c, ng_c, jump_c, commit_c;
    logic [ADDR_W-1:0] target_c;

    // Hack ALU on the latched instruction; y selects MDR when the a-bit is set
    always_comb begin
        alu_x_c = ir_q[11] ? '0 : d_q;
        if (ir_q[10]) alu_x_c = ~alu_x_c;
        alu_y_c = ir_q[12] ? mdr_q : a_q;
        if (ir_q[9]) alu_y_c = '0;
        if (ir_q[8]) alu_y_c = ~alu_y_c;
        alu_r_c = ir_q[7] ? (alu_x_c + alu_y_c) : (alu_x_c & alu_y_c);
        if (ir_q[6]) alu_r_c = ~alu_r_c;
    end

    assign is_c_c   = ir_q[DATA_W-1];
    assign zr_c     = (alu_r_c == '0);
    assign ng_c     = alu_r_c[DATA_W-1];
    assign jump_c   = is_c_c & ((ir_q[2] & ng_c) | (ir_q[1] & zr_c) | (ir_q[0] & ~ng_c & ~zr_c));
    assign target_c = a_q[ADDR_W-1:0];

    // Next-state and architectural update; commit happens from EXEC or an acked WRITE
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        d_d      = d_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        mdr_d    = mdr_q;
        wdata_d  = wdata_q;
        retire_d = 1'b0;
        halt_d   = halt_q;
        commit_c = 1'b0;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: if (imem_ack_i) begin
                ir_d    = imem_data_i;
                state_d = (imem_data_i[DATA_W-1] && imem_data_i[12]) ? READ : EXEC;
            end
            READ:  if (dmem_ack_i) begin
                mdr_d   = dmem_data_i;
                state_d = EXEC;
            end
            EXEC:  if (is_c_c && ir_q[3]) begin
                wdata_d = alu_r_c;
                state_d = WRITE;
            end else begin
                commit_c = 1'b1;
            end
            WRITE: if (dmem_ack_i) commit_c = 1'b1;
`ifdef CPU_HALT_DETECT_EN
            HALT:  state_d = HALT;
`endif
            default: state_d = IDLE;
        endcase
        if (commit_c) begin
            retire_d = 1'b1;
            state_d  = FETCH;
            if (!is_c_c) begin
                a_d = {1'b0, ir_q[DATA_W-2:0]};
            end else begin
                if (ir_q[4]) d_d = alu_r_c;
                if (ir_q[5]) a_d = alu_r_c;
            end
            pc_d = jump_c ? target_c : pc_q + ADDR_W'(1);
`ifdef CPU_HALT_DETECT_EN
            if (jump_c && (target_c == pc_q)) begin
                state_d = HALT;
                halt_d  = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            a_q        <= '0;
            d_q        <= '0;
            pc_q       <= '0;
            ir_q       <= '0;
            mdr_q      <= '0;
            wdata_q    <= '0;
            retire_q   <= 1'b0;
            halt_q     <= 1'b0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            d_q        <= d_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            mdr_q      <= mdr_d;
            wdata_q    <= wdata_d;
            retire_q   <= retire_d;
            halt_q     <= halt_d;
            imem_req_q <= (state_d == FETCH);
            dmem_req_q <= (state_d == READ) || (state_d == WRITE);
            dmem_we_q  <= (state_d == WRITE);
        end
    end

    assign imem_req_o  = imem_req_q;
    assign imem_addr_o = pc_q;
    assign dmem_req_o  = dmem_req_q;
    assign dmem_we_o   = dmem_we_q;
    assign dmem_addr_o = a_q[ADDR_W-1:0];
    assign dmem_data_o = wdata_q;
    assign pc_o        = pc_q;
    assign retire_o    = retire_q;
`ifdef CPU_HALT_DETECT_EN
    assign halt_o      = halt_q;
`else
    assign halt_o      = 1'b0;
`endif

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Bench for hack_cpu_mc: directed program plus random programs checked by an instruction-level model.
module tb_hack_cpu_mc;

    logic        clk_i, reset_ni;
    logic        imem_req_o, imem_ack_i, dmem_req_o, dmem_we_o, dmem_ack_i;
    logic [14:0] imem_addr_o, dmem_addr_o, pc_o;
    logic [15:0] imem_data_i, dmem_data_o, dmem_data_i;
    logic        retire_o, halt_o;

    hack_cpu_mc #(.DATA_W(16), .ADDR_W(15)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_data_o(dmem_data_o),
        .dmem_ack_i(dmem_ack_i), .dmem_data_i(dmem_data_i),
        .pc_o(pc_o), .retire_o(retire_o), .halt_o(halt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct { logic [14:0] addr; logic [15:0] data; } wr_t;

    logic [15:0] rom  [32768];
    logic [15:0] ram  [32768];
    logic [15:0] mram [32768];
    wr_t         wq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int i_wait = 0, d_wait = 0;
    bit rnd_wait = 0;
    bit i_busy = 0, d_busy = 0;
    int i_cnt = 0, d_cnt = 0;

    logic [15:0] m_a, m_d;
    logic [14:0] m_pc;
    bit          m_halt;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_alu(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
        logic [15:0] xx, yy, r;
        xx = c[5] ? 16'h0 : x;
        xx = c[4] ? ~xx : xx;
        yy = c[3] ? 16'h0 : y;
        yy = c[2] ? ~yy : yy;
        r  = c[1] ? 16'(xx + yy) : (xx & yy);
        return c[0] ? ~r : r;
    endfunction

    // Execute one whole instruction in the model and compare with the retired DUT state
    task automatic model_step();
        logic [15:0] ins, y, r, old_a;
        logic [14:0] nxt;
        logic        zr, ng, take;
        wr_t         w;
        ins = rom[m_pc];
        if (!ins[15]) begin
            m_a  = {1'b0, ins[14:0]};
            m_pc = m_pc + 15'd1;
        end else begin
            old_a = m_a;
            y     = ins[12] ? mram[old_a[14:0]] : old_a;
            r     = ref_alu(m_d, y, ins[11:6]);
            zr    = (r == 16'h0);
            ng    = r[15];
            take  = (ins[2] && ng) || (ins[1] && zr) || (ins[0] && !ng && !zr);
            if (ins[3]) begin
                check_eq("wr_missing", wq.size(), 1);
                if (wq.size() > 0) begin
                    w = wq.pop_front();
                    check_eq("wr_addr", w.addr, old_a[14:0]);
                    check_eq("wr_data", w.data, r);
                end
                mram[old_a[14:0]] = r;
            end
            if (ins[4]) m_d = r;
            if (ins[5]) m_a = r;
            nxt = take ? old_a[14:0] : m_pc + 15'd1;
`ifdef CPU_HALT_DETECT_EN
            if (take && nxt == m_pc) m_halt = 1'b1;
`endif
            m_pc = nxt;
        end
        check_eq("wr_extra", wq.size(), 0);
        check_eq("retire_pc", pc_o, m_pc);
        check_eq("retire_halt", halt_o, m_halt);
    endtask

    // Memory responder with configurable wait states, followed by the model monitor
    always @(negedge clk_i) begin
        imem_ack_i = 1'b0;
        dmem_ack_i = 1'b0;
        if (!reset_ni) begin
            i_busy = 0; d_busy = 0;
            m_a = 16'h0; m_d = 16'h0; m_pc = 15'h0; m_halt = 1'b0;
            wq.delete();
        end else begin
            if (imem_req_o) begin
                if (!i_busy) begin
                    i_busy = 1;
                    i_cnt  = rnd_wait ? int'($urandom_range(0, 2)) : i_wait;
                end
                if (i_cnt == 0) begin
                    imem_ack_i  = 1'b1;
                    imem_data_i = rom[imem_addr_o];
                    i_busy      = 0;
                end else i_cnt--;
            end
            if (dmem_req_o) begin
                if (!d_busy) begin
                    d_busy = 1;
                    d_cnt  = rnd_wait ? int'($urandom_range(0, 3)) : d_wait;
                end
                if (d_cnt == 0) begin
                    dmem_ack_i = 1'b1;
                    d_busy     = 0;
                    if (dmem_we_o) begin
                        ram[dmem_addr_o] = dmem_data_o;
                        wq.push_back('{addr: dmem_addr_o, data: dmem_data_o});
                    end else begin
                        dmem_data_i = ram[dmem_addr_o];
                    end
                end else d_cnt--;
            end
            if (retire_o) model_step();
        end
    end

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic wait_retire();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!retire_o && n < 200);
        check_eq("retire_seen", retire_o, 1'b1);
    endtask

    task automatic wait_dreq(input logic we);
        int n = 0;
        while (!(dmem_req_o && dmem_we_o == we) && n < 200) begin
            tick();
            n++;
        end
        check_eq("dreq_seen", dmem_req_o, 1'b1);
    endtask

    task automatic load_directed();
        for (int k = 0; k < 32768; k++) begin
            rom[k] = 16'h0; ram[k] = 16'h0; mram[k] = 16'h0;
        end
        rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'd100; rom[3] = 16'hE308;
        rom[4] = 16'd101;  rom[5] = 16'hFC10; rom[6] = 16'd2;   rom[7] = 16'hE301;
        rom[8] = 16'd100;  rom[9] = 16'hE308; rom[10] = 16'd11; rom[11] = 16'hEA87;
        ram[101] = 16'h0007; mram[101] = 16'h0007;
    endtask

    initial begin
        int cnt;
        reset_ni = 1'b0;
        imem_ack_i = 1'b0; dmem_ack_i = 1'b0;
        imem_data_i = 16'h0; dmem_data_i = 16'h0;
        load_directed();
        i_wait = 0; d_wait = 3; rnd_wait = 0;
        repeat (3) tick();
        check_eq("rst_pc", pc_o, 0);
        check_eq("rst_imem_req", imem_req_o, 0);
        check_eq("rst_imem_addr", imem_addr_o, 0);
        check_eq("rst_dmem_req", dmem_req_o, 0);
        check_eq("rst_dmem_we", dmem_we_o, 0);
        check_eq("rst_dmem_addr", dmem_addr_o, 0);
        check_eq("rst_dmem_data", dmem_data_o, 0);
        check_eq("rst_retire", retire_o, 0);
        check_eq("rst_halt", halt_o, 0);

        reset_ni = 1'b1;
        tick();
        check_eq("first_fetch", imem_req_o, 1);
        check_eq("lat_c1_retire", retire_o, 0);
        tick();
        check_eq("lat_c2_retire", retire_o, 0);
        check_eq("a_inst_no_dreq", dmem_req_o, 0);
        tick();
        check_eq("lat_c3_retire", retire_o, 1);
        check_eq("pc_after_at5", pc_o, 1);
        tick();
        check_eq("dis_c1_retire", retire_o, 0);
        tick();
        check_eq("dis_c2_retire", retire_o, 1);
        check_eq("pc_after_dis", pc_o, 2);

        wait_dreq(1'b1);
        for (int k = 0; k < 4; k++) begin
            check_eq("wr_hold_req", dmem_req_o, 1);
            check_eq("wr_hold_we", dmem_we_o, 1);
            check_eq("wr_hold_addr", dmem_addr_o, 100);
            check_eq("wr_hold_data", dmem_data_o, 5);
            check_eq("wr_hold_pc", pc_o, 3);
            tick();
        end
        check_eq("wr_commit_retire", retire_o, 1);
        check_eq("wr_commit_pc", pc_o, 4);
        wait_retire();
        wait_dreq(1'b0);
        check_eq("rd_we", dmem_we_o, 0);
        check_eq("rd_addr", dmem_addr_o, 101);
        repeat (3) wait_retire();
        check_eq("jgt_taken_pc", pc_o, 2);
        ram[101] = 16'hFFFF; mram[101] = 16'hFFFF;
        repeat (6) wait_retire();
        check_eq("jgt_not_taken_pc", pc_o, 8);
        repeat (4) wait_retire();
        check_eq("self_loop_pc", pc_o, 11);
`ifdef CPU_HALT_DETECT_EN
        check_eq("halt_set", halt_o, 1);
        cnt = 0;
        repeat (10) begin
            tick();
            if (imem_req_o || dmem_req_o || retire_o) cnt++;
        end
        check_eq("halt_quiet", cnt, 0);
        check_eq("halt_sticky", halt_o, 1);
`else
        repeat (2) wait_retire();
        check_eq("loop_pc", pc_o, 11);
        check_eq("loop_fetch_addr", imem_addr_o, 11);
        check_eq("loop_no_halt", halt_o, 0);
`endif

        // Abort a long-stalled write with reset
        reset_ni = 1'b0;
        tick();
        load_directed();
        d_wait = 20;
        reset_ni = 1'b1;
        wait_dreq(1'b1);
        repeat (2) tick();
        #2;
        reset_ni = 1'b0;
        #1;
        check_eq("abort_dreq", dmem_req_o, 0);
        check_eq("abort_we", dmem_we_o, 0);
        check_eq("abort_pc", pc_o, 0);
        check_eq("abort_imem_req", imem_req_o, 0);
        tick();

        // Random programs with random wait states
        for (int k = 0; k < 32768; k++) begin
            rom[k]  = 16'($urandom);
            ram[k]  = 16'($urandom);
            mram[k] = ram[k];
        end
        rnd_wait = 1;
        tick();
        reset_ni = 1'b1;
        for (int k = 0; k < 500; k++) begin
            wait_retire();
            if (halt_o) break;
        end
        tick();
        check_eq("final_wq_empty", wq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hack_cpu_mc.md
# hack_cpu_mc

Multi-cycle, parametrised Hack CPU core with request/acknowledge handshakes on separate instruction and data memory ports. It generalises the single-cycle Hack CPU datapath (A, D, PC, ALU) in several ways:
- data and address widths are parameters;
- memory accesses tolerate wait states;
- completed instructions are reported on a retire pulse.

It sits between the instruction ROM and the data RAM/MMIO fabric, replacing the single-cycle core wherever memories are not zero-latency.

## Interface
- DATA_W, 16: datapath width (A, D, ALU, memory data); must be ≥ 16.
- ADDR_W, 15: address width for the PC and data memory; must be ≤ DATA_W-1.

- clk_i  input  1  clock; all state updates on the rising edge.
- reset_ni  input  1  asynchronous, active-low reset.
- imem_req_o  output  1  instruction fetch request.
- imem_addr_o  output  ADDR_W  fetch address (= PC).
- imem_ack_i  input  1  fetch complete; imem_data_i is valid this cycle.
- imem_data_i  input  DATA_W  instruction word.
- dmem_req_o  output  1  data access request.
- dmem_we_o  output  1  1 = write, 0 = read; qualified by dmem_req_o.
- dmem_addr_o  output  ADDR_W  data address = A[ADDR_W-1:0].
- dmem_data_o  output  DATA_W  write data (ALU result).
- dmem_ack_i  input  1  access complete; read data is valid on dmem_data_i this cycle.
- dmem_data_i  input  DATA_W  read data (M).
- pc_o  output  ADDR_W  current PC.
- retire_o  output  1  one-cycle pulse per committed instruction.
- halt_o  output  1  sticky halt indication (see Configuration).

## Operation
Instruction decode:
- An instruction is a C-instruction when bit DATA_W-1 is 1; otherwise it is an A-instruction.
- A-instruction: A ← instr[DATA_W-2:0], zero-extended to DATA_W.
- C-instruction fields are instr[12:0] in standard Hack order: a, zx, nx, zy, ny, f, no, d1–d3, j1–j3. Bits [DATA_W-2:13] are ignored.
- The ALU is the Hack ALU at DATA_W bits. x = D; y = a ? M : A. Arithmetic wraps modulo 2^DATA_W.
- zr = (result == 0); ng = result[DATA_W-1].
- Jump condition: (j1 & ng) | (j2 & zr) | (j3 & ~ng & ~zr).
- A jump target is the old A (the value before this instruction's A write), truncated to ADDR_W.
- PC increments modulo 2^ADDR_W.

FSM states: IDLE, FETCH, READ, EXEC, WRITE, HALT.
- IDLE: reset state. Goes to FETCH on the next cycle.
- FETCH: imem_req_o = 1. On imem_ack_i, latch IR. Next state is READ if the instruction is a C-instruction with a = 1; otherwise EXEC.
- READ: dmem_req_o = 1, dmem_we_o = 0. On dmem_ack_i, latch MDR and go to EXEC.
- EXEC: go to WRITE if d3 = 1. Otherwise commit and go to FETCH (or HALT).
- WRITE: dmem_req_o = 1, dmem_we_o = 1. On dmem_ack_i, commit and go to FETCH (or HALT).
- Commit means, in the same edge:
  - load D if d2;
  - load A if d1 (or with the immediate for an A-instruction);
  - load PC with the jump target or PC+1;
  - pulse retire_o for one cycle.

Handshake rules:
- A request stays asserted, with address, data and we held stable, until acknowledged.
- An ack received while the matching request is low is ignored.
- Both requests are never high in the same cycle.

## Timing
- Reset values: all outputs 0, including pc_o, imem_addr_o, dmem_addr_o, dmem_data_o and halt_o. A, D, PC, IR, MDR = 0. State = IDLE.
- First imem_req_o rises in the first cycle after the first clock edge following reset release.
- Latency with zero-wait acks (ack in the same cycle as the request):
  - A-instruction or C-instruction without M access: 2 cycles (FETCH, EXEC).
  - M read: 3 cycles.
  - M write: 3 cycles.
  - Read-modify-write: 4 cycles.
- Each wait cycle on an ack adds exactly one cycle.
- retire_o is registered and high for the cycle following the commit edge.
- Reset asserted mid-operation, including while a request is pending, clears everything immediately. The aborted instruction has no architectural effect.

## Configuration
- CPU_HALT_DETECT_EN defined:
  - A committed C-instruction with a taken jump whose target equals its own PC sets halt_o (sticky) and enters HALT.
  - In HALT, no further requests are issued until reset.
  - retire_o still pulses for that instruction.
- CPU_HALT_DETECT_EN undefined:
  - halt_o is tied to 0 and the HALT state is absent.
  - A self-loop keeps fetching indefinitely.

## Test plan
- Reset, zero-wait acks, PC0 = 0x0005 (@5): A = 5, PC = 1; retire_o pulses 3 cycles after reset release; no dmem_req_o.
- PC1 = 0xEC10 (D=A): D = 5, PC = 2; 2 cycles per instruction.
- @100 followed by 0xE308 (M=D), dmem_ack_i delayed 3 cycles: dmem_req_o = 1, dmem_we_o = 1, addr = 100, data = 5 held stable for 4 cycles; PC advances only on the ack.
- 0xFC10 (D=M) with dmem_data_i = 0x0007 on ack: D = 7, dmem_we_o = 0.
- D = 7, A = 2, 0xE301 (D;JGT): PC becomes 2. Then D = 0xFFFF (negative), 0xE301: PC becomes PC+1.
- At PC 10, @11; at PC 11, 0xEA87 (0;JMP):
  - with CPU_HALT_DETECT_EN: halt_o = 1 and imem_req_o stays 0;
  - without it: the core repeatedly fetches 11.
  - Reset asserted mid-WRITE: dmem_req_o drops immediately and pc_o = 0.
